// File: rtl/sprite_motion_ctl_if.sv
// Control and position bundle between the sprite motion controller and its
// neighbours: vSync and button pulses come in, and coordinates and status go out.
interface sprite_motion_ctl_if;
    logic               vSync;
    logic               btnX;
    logic               btnY;
    logic signed [10:0] spr_x;
    logic signed [9:0]  spr_y;
    logic               dirX;
    logic               dirY;
    logic               running;
    logic               frameTick;

    // Driver side: video timing, buttons, and the sprite drawing stage.
    modport master (
        output vSync, btnX, btnY,
        input  spr_x, spr_y, dirX, dirY, running, frameTick
    );

    // Motion controller side.
    modport slave (
        input  vSync, btnX, btnY,
        output spr_x, spr_y, dirX, dirY, running, frameTick
    );
endinterface

// File: rtl/sprite_motion_ctl.sv
// Frame-synchronous sprite position generator. On the rising edge of vSync the
// sprite steps once every FRAME_DIV frames and bounces off the screen edges.
// btnX toggles between run and pause. btnY cycles the step size through 1, 2, 4 and 8.
module sprite_motion_ctl #(
    parameter int SCREEN_W  = 1280,
    parameter int SCREEN_H  = 720,
    parameter int SPR_SIZE  = 8,
    parameter int FRAME_DIV = 1      // 1..255
) (
    input  logic               pixelClk,
    input  logic               reset,
    sprite_motion_ctl_if.slave bus
);

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_PAUSED = 1'b1
    } state_e;

    localparam logic signed [11:0] MAX_X    = 12'(SCREEN_W - SPR_SIZE);
    localparam logic signed [10:0] MAX_Y    = 11'(SCREEN_H - SPR_SIZE);
    localparam logic        [7:0]  DIV_LAST = 8'(FRAME_DIV - 1);

    state_e      state_q, state_d;
    logic        vsync_prev_q, vsync_prev_d;
    logic [7:0]  div_cnt_q, div_cnt_d;
    logic [1:0]  speed_idx_q, speed_idx_d;
    logic [10:0] spr_x_q, spr_x_d;
    logic [9:0]  spr_y_q, spr_y_d;
    logic        dir_x_q, dir_x_d;
    logic        dir_y_q, dir_y_d;
    logic        tick_q, tick_d;

    logic               frame_edge;
    logic signed [11:0] pos_x, step_x, next_x;
    logic signed [10:0] pos_y, step_y, next_y;

    // Next-state logic: detect the vSync edge, divide frames, step and bounce, and handle buttons.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        vsync_prev_d = bus.vSync;
        frame_edge   = bus.vSync & ~vsync_prev_q;
        tick_d       = frame_edge;
        state_d      = state_q;
        div_cnt_d    = div_cnt_q;
        speed_idx_d  = speed_idx_q;
        spr_x_d      = spr_x_q;
        spr_y_d      = spr_y_q;
        dir_x_d      = dir_x_q;
        dir_y_d      = dir_y_q;

        // Positions are never negative, so the stored fields are zero-extended
        // before the signed step. This keeps 1272 and 712 valid.
        pos_x  = {1'b0, spr_x_q};
        pos_y  = {1'b0, spr_y_q};
        step_x = 12'sd1 <<< speed_idx_q;
        step_y = 11'sd1 <<< speed_idx_q;
        next_x = dir_x_q ? pos_x - step_x : pos_x + step_x;
        next_y = dir_y_q ? pos_y - step_y : pos_y + step_y;

        if (frame_edge) begin
            if (div_cnt_q == DIV_LAST) begin
                div_cnt_d = '0;
                if (state_q == ST_RUN) begin
                    if (next_x > MAX_X) begin
                        spr_x_d = MAX_X[10:0];
                        dir_x_d = 1'b1;
                    end else if (next_x < 12'sd0) begin
                        spr_x_d = '0;
                        dir_x_d = 1'b0;
                    end else begin
                        spr_x_d = next_x[10:0];
                    end

                    if (next_y > MAX_Y) begin
                        spr_y_d = MAX_Y[9:0];
                        dir_y_d = 1'b1;
                    end else if (next_y < 11'sd0) begin
                        spr_y_d = '0;
                        dir_y_d = 1'b0;
                    end else begin
                        spr_y_d = next_y[9:0];
                    end
                end
            end else begin
                div_cnt_d = div_cnt_q + 8'd1;
            end
        end

        // The buttons act on the _d values only. An update in the same cycle
        // still sees the old state and speed.
        if (!bus.btnX) begin
            state_d = (state_q == ST_RUN) ? ST_PAUSED : ST_RUN;
        end
        if (!bus.btnY) begin
            speed_idx_d = speed_idx_q + 2'd1;
        end
    end

    // State register: the run/pause FSM, the divider, the speed, and all registered outputs.
    always_ff @(posedge pixelClk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_RUN;
            // A high reset value means vSync already high at reset release is not an edge.
            vsync_prev_q <= 1'b1;
            div_cnt_q    <= '0;
            speed_idx_q  <= '0;
            spr_x_q      <= '0;
            spr_y_q      <= '0;
            dir_x_q      <= 1'b0;
            dir_y_q      <= 1'b0;
            tick_q       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q      <= state_d;
            vsync_prev_q <= vsync_prev_d;
            div_cnt_q    <= div_cnt_d;
            speed_idx_q  <= speed_idx_d;
            spr_x_q      <= spr_x_d;
            spr_y_q      <= spr_y_d;
            dir_x_q      <= dir_x_d;
            dir_y_q      <= dir_y_d;
            tick_q       <= tick_d;
        end
    end

    assign bus.spr_x     = spr_x_q;
    assign bus.spr_y     = spr_y_q;
    assign bus.dirX      = dir_x_q;
    assign bus.dirY      = dir_y_q;
    assign bus.running   = (state_q == ST_RUN);
    assign bus.frameTick = tick_q;

endmodule

// File: tb/tb_sprite_motion_ctl.sv
// Scoreboard bench for sprite_motion_ctl. Two instances, with FRAME_DIV=1 and
// FRAME_DIV=3, share the same stimulus. On every vSync edge a reference model
// pushes the expected outputs, and each frameTick pops and compares one entry.
module tb_sprite_motion_ctl;

    localparam int MAXX = 1280 - 8;
    localparam int MAXY = 720 - 8;

    typedef struct {
        int x;
        int y;
        int dx;
        int dy;
        int run;
    } exp_t;

    logic pixelClk = 1'b0;
    logic reset    = 1'b1;
    logic vsync    = 1'b0;
    logic btn_x    = 1'b1;
    logic btn_y    = 1'b1;

    int n_checks = 0;
    int n_errors = 0;
    int n_ticks0 = 0;
    int n_ticks1 = 0;

    // Reference model state, one slot per instance.
    int m_x [2];
    int m_y [2];
    int m_dx [2];
    int m_dy [2];
    int m_run [2];
    int m_spd [2];
    int m_div [2];

    exp_t sb0[$];
    exp_t sb1[$];
    exp_t e0, e1;

    sprite_motion_ctl_if ifc0 ();
    sprite_motion_ctl_if ifc1 ();

    assign ifc0.vSync = vsync;
    assign ifc0.btnX  = btn_x;
    assign ifc0.btnY  = btn_y;
    assign ifc1.vSync = vsync;
    assign ifc1.btnX  = btn_x;
    assign ifc1.btnY  = btn_y;

    sprite_motion_ctl #(.FRAME_DIV(1)) dut0 (
        .pixelClk (pixelClk),
        .reset    (reset),
        .bus      (ifc0)
    );

    sprite_motion_ctl #(.FRAME_DIV(3)) dut1 (
        .pixelClk (pixelClk),
        .reset    (reset),
        .bus      (ifc1)
    );

    always #5 pixelClk = ~pixelClk;

    task automatic check(input string tag, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic int div_of(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 2; i++) begin
            m_x[i] = 0; m_y[i] = 0; m_dx[i] = 0; m_dy[i] = 0;
            m_run[i] = 1; m_spd[i] = 0; m_div[i] = 0;
        end
        sb0.delete();
        sb1.delete();
    endfunction

    function automatic void model_btn(input int i, input bit px, input bit py);
        if (px) m_run[i] = 1 - m_run[i];
        if (py) m_spd[i] = (m_spd[i] + 1) % 4;
    endfunction

    // One vSync edge, with optional button pulses in the same cycle.
    function automatic void model_edge(input int i, input bit px, input bit py);
        exp_t e;
        int   step, nx, ny;
        if (m_div[i] == div_of(i) - 1) begin
            m_div[i] = 0;
            if (m_run[i] == 1) begin
                step = 1 << m_spd[i];
                nx = (m_dx[i] == 1) ? m_x[i] - step : m_x[i] + step;
                ny = (m_dy[i] == 1) ? m_y[i] - step : m_y[i] + step;
                if (nx > MAXX) begin m_x[i] = MAXX; m_dx[i] = 1; end
                else if (nx < 0) begin m_x[i] = 0; m_dx[i] = 0; end
                else m_x[i] = nx;
                if (ny > MAXY) begin m_y[i] = MAXY; m_dy[i] = 1; end
                else if (ny < 0) begin m_y[i] = 0; m_dy[i] = 0; end
                else m_y[i] = ny;
            end
        end else begin
            m_div[i]++;
        end
        model_btn(i, px, py);
        e.x = m_x[i]; e.y = m_y[i]; e.dx = m_dx[i]; e.dy = m_dy[i]; e.run = m_run[i];
        if (i == 0) sb0.push_back(e);
        else        sb1.push_back(e);
    endfunction

    task automatic compare(input string tag, input exp_t e, input int x, input int y,
                           input int dx, input int dy, input int run);
        check({"x", tag}, x, e.x);
        check({"y", tag}, y, e.y);
        check({"dirX", tag}, dx, e.dx);
        check({"dirY", tag}, dy, e.dy);
        check({"running", tag}, run, e.run);
    endtask

    // Monitors: each frameTick consumes exactly one expected entry.
    always @(negedge pixelClk) begin
        if (!reset && ifc0.frameTick) begin
            n_ticks0++;
            if (sb0.size() == 0) check("tick0_unexpected", 1, 0);
            else begin
                e0 = sb0.pop_front();
                compare("0", e0, int'($unsigned(ifc0.spr_x)), int'($unsigned(ifc0.spr_y)),
                        int'(ifc0.dirX), int'(ifc0.dirY), int'(ifc0.running));
            end
        end
    end

    always @(negedge pixelClk) begin
        if (!reset && ifc1.frameTick) begin
            n_ticks1++;
            if (sb1.size() == 0) check("tick1_unexpected", 1, 0);
            else begin
                e1 = sb1.pop_front();
                compare("1", e1, int'($unsigned(ifc1.spr_x)), int'($unsigned(ifc1.spr_y)),
                        int'(ifc1.dirX), int'(ifc1.dirY), int'(ifc1.running));
            end
        end
    end

    task automatic frame(input bit px = 1'b0, input bit py = 1'b0);
        @(negedge pixelClk);
        vsync = 1'b1; btn_x = ~px; btn_y = ~py;
        model_edge(0, px, py);
        model_edge(1, px, py);
        @(negedge pixelClk);
        btn_x = 1'b1; btn_y = 1'b1;
        repeat (2) @(negedge pixelClk);
        vsync = 1'b0;
        repeat (2) @(negedge pixelClk);
    endtask

    task automatic press(input bit px, input bit py);
        @(negedge pixelClk);
        btn_x = ~px; btn_y = ~py;
        model_btn(0, px, py);
        model_btn(1, px, py);
        @(negedge pixelClk);
        btn_x = 1'b1; btn_y = 1'b1;
    endtask

    function automatic int x0();
        return int'($unsigned(ifc0.spr_x));
    endfunction

    initial begin
        int saved_x, saved_y, t0, guard;

        model_reset();
        repeat (3) @(negedge pixelClk);
        reset = 1'b0;
        repeat (2) @(negedge pixelClk);
        check("rst_spr_x", x0(), 0);
        check("rst_spr_y", int'($unsigned(ifc0.spr_y)), 0);
        check("rst_dirX", int'(ifc0.dirX), 0);
        check("rst_dirY", int'(ifc0.dirY), 0);
        check("rst_running", int'(ifc0.running), 1);
        check("rst_frameTick", int'(ifc0.frameTick), 0);

        // Three frames at speed 1.
        repeat (3) frame();
        check("x_after3", x0(), 3);
        check("y_after3", int'($unsigned(ifc0.spr_y)), 3);
        check("ticks_after3", n_ticks0, 3);
        check("div3_x_after3", int'($unsigned(ifc1.spr_x)), 1);

        // Speed 8. X reaches the right edge and bounces. Y bounces along the way.
        repeat (3) press(1'b0, 1'b1);
        repeat (159) frame();
        check("x_clamp", x0(), 1272);
        check("dirX_clamp", int'(ifc0.dirX), m_dx[0]);
        frame();
        check("x_after_bounce", x0(), 1264);
        check("dirX_after_bounce", int'(ifc0.dirX), 1);

        // Pause: five frames tick without any motion. Resume: one step.
        press(1'b1, 1'b0);
        check("running_paused", int'(ifc0.running), 0);
        saved_x = m_x[0];
        saved_y = m_y[0];
        t0 = n_ticks0;
        repeat (5) frame();
        check("x_paused", x0(), saved_x);
        check("y_paused", int'($unsigned(ifc0.spr_y)), saved_y);
        check("ticks_paused", n_ticks0 - t0, 5);
        press(1'b1, 1'b0);
        frame();
        check("x_resumed", x0(), saved_x - 8);

        // Speed wraps from 8 to 1. A pause pulse on the edge cycle still moves.
        press(1'b0, 1'b1);
        saved_x = m_x[0];
        frame(1'b1, 1'b0);
        check("x_pause_same_cycle", x0(), saved_x - 1);
        check("running_same_cycle", int'(ifc0.running), 0);
        press(1'b1, 1'b0);

        // Travel to x=500, then assert reset while vSync is low.
        guard = 0;
        while (m_x[0] != 500 && guard < 3000) begin
            frame();
            guard++;
        end
        check("x_pre_reset", x0(), 500);
        @(negedge pixelClk);
        #2 reset = 1'b1;
        #1;
        check("async_rst_x", x0(), 0);
        check("async_rst_running", int'(ifc0.running), 1);
        model_reset();
        t0 = n_ticks0;
        @(negedge pixelClk);
        vsync = 1'b1;
        repeat (3) @(negedge pixelClk);
        reset = 1'b0;
        repeat (4) @(negedge pixelClk);
        check("no_edge_on_release_x", x0(), 0);
        check("no_edge_on_release_ticks", n_ticks0 - t0, 0);
        vsync = 1'b0;
        repeat (2) @(negedge pixelClk);

        // Nine frames: the FRAME_DIV=3 instance updates on edges 3, 6 and 9.
        t0 = n_ticks1;
        repeat (9) frame();
        check("x_after9", x0(), 9);
        check("div3_x_after9", int'($unsigned(ifc1.spr_x)), 3);
        check("div3_ticks", n_ticks1 - t0, 9);

        repeat (3) @(negedge pixelClk);
        check("sb0_drained", sb0.size(), 0);
        check("sb1_drained", sb1.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
